// File: rtl/piso_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | piso_pkg : shared types/constants for the PISO serial transmitter  |
// | PISO_TX_PARITY_EN adds the PARITY state.            Revision: 1.0  |
// +--------------------------------------------------------------------+
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 10;

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DONE   = 2'd2,
        ST_PARITY = 2'd3
    } piso_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DONE   = 2'd2
    } piso_state_t;
`endif

    // Counter holds WIDTH-1 down to 0.
    function automatic int piso_cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | piso_shift_tx_if : load handshake + serial side of piso_shift_tx   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface piso_shift_tx_if #(
    parameter int WIDTH = piso_pkg::PISO_DEFAULT_WIDTH
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_ready;
    logic             ser_valid;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data, ser_ready,
        input  load_ready, ser_valid, ser_out, busy, done
    );

    modport slave (
        input  load_valid, load_data, ser_ready,
        output load_ready, ser_valid, ser_out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | piso_bit_counter : loadable down-counter with zero flag            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module piso_bit_counter #(
    parameter int CNT_W = 4
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              load,
    input  wire              dec,
    input  wire  [CNT_W-1:0] load_value,
    output logic             zero
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
endmodule
`default_nettype wire

// File: rtl/piso_shift_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | piso_shift_tx : parallel-in serial-out transmitter, MSB first      |
// | PISO_TX_PARITY_EN appends an even-parity bit.       Revision: 1.0  |
// +--------------------------------------------------------------------+
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
    input  wire            clk,
    input  wire            reset,
    piso_shift_tx_if.slave bus
);
    localparam int               CNT_W      = piso_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             load_ready_q, load_ready_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_out_q, ser_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic             beat;
    logic             cnt_zero;
`ifdef PISO_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Accept only once load_ready is visible, so the first edge after reset is never an accept.
    assign accept = (state_q == ST_IDLE) && load_ready_q && bus.load_valid;
    assign beat   = ser_valid_q && bus.ser_ready;

    piso_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .dec        (beat && (state_q == ST_SHIFT)),
        .load_value (C_LAST_IDX),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shift_d = bus.load_data;
                end
            end
            ST_SHIFT: begin
                if (beat) begin
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    if (cnt_zero) begin
`ifdef PISO_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef PISO_TX_PARITY_EN
            ST_PARITY: begin
                if (beat) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so every port comes straight off a flop.
        load_ready_d = (state_d == ST_IDLE);
        ser_valid_d  = (state_d == ST_SHIFT);
        ser_out_d    = (state_d == ST_SHIFT) ? shift_d[WIDTH-1] : 1'b0;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
`ifdef PISO_TX_PARITY_EN
        parity_d = accept ? ^bus.load_data : parity_q;
        if (state_d == ST_PARITY) begin
            ser_valid_d = 1'b1;
            ser_out_d   = parity_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            load_ready_q <= 1'b0;
            ser_valid_q  <= 1'b0;
            ser_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            load_ready_q <= load_ready_d;
            ser_valid_q  <= ser_valid_d;
            ser_out_q    <= ser_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef PISO_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign bus.load_ready = load_ready_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.ser_out    = ser_out_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_piso_shift_tx : table-driven scoreboard bench for piso_shift_tx |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_piso_shift_tx;
    localparam int W = 10;
`ifdef PISO_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    piso_shift_tx_if #(.WIDTH(W)) bus ();

    piso_shift_tx #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [W-1:0] data;
        int           stall_after;
        int           stall_cyc;
        int           exp_lat;
        bit           exp_par;
        bit           hold_valid;
    } vec_t;

    vec_t vecs[6];
    bit   exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   acc_edge = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic run_vec(input vec_t v);
        int  k;
        int  beats;
        int  st;
        int  tmo;
        bit  got_done;
        bus.load_valid = 1'b1;
        bus.load_data  = v.data;
        tmo = 0;
        while (bus.load_ready !== 1'b1 && tmo < 40) begin
            @(negedge clk);
            tmo++;
        end
        if (bus.load_ready !== 1'b1) begin
            chk("accept_timeout", 0, 1);
            bus.load_valid = 1'b0;
            return;
        end
        acc_edge = edge_cnt + 1;
        for (int b = W - 1; b >= 0; b--) exp_q.push_back(v.data[b]);
        if (PAR != 0) exp_q.push_back(v.exp_par);
        @(posedge clk);
        #1;
        if (v.hold_valid) bus.load_data = 10'h3FF;
        else bus.load_valid = 1'b0;

        beats    = 0;
        st       = 0;
        got_done = 1'b0;
        for (k = 0; k < 60; k++) begin
            if (beats == v.stall_after && st < v.stall_cyc) begin
                bus.ser_ready = 1'b0;
                st++;
            end else begin
                bus.ser_ready = 1'b1;
            end
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            chk("busy_during_tx", bus.busy, 1);
            chk("load_ready_during_tx", bus.load_ready, 0);
            chk("ser_valid_during_tx", bus.ser_valid, 1);
            if (exp_q.size() == 0) begin
                chk("extra_serial_bit", 1, 0);
            end else begin
                chk("ser_out", bus.ser_out, exp_q[0]);
                if (bus.ser_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("done_seen", got_done, 1);
        if (got_done) begin
            chk("done_latency", k, v.exp_lat + PAR);
            chk("busy_at_done", bus.busy, 1);
            chk("ser_valid_at_done", bus.ser_valid, 0);
            chk("bits_left_at_done", exp_q.size(), 0);
        end
        exp_q.delete();
        bus.ser_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("load_ready_after_done", bus.load_ready, 1);
        chk("busy_after_done", bus.busy, 0);
    endtask

    initial begin
        int prev_acc;
        int seen_done;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.ser_ready  = 1'b0;

        vecs[0] = '{10'h2C5, -1, 0, 10, 1'b1, 1'b0};
        vecs[1] = '{10'h2C5,  4, 3, 13, 1'b1, 1'b0};
        vecs[2] = '{10'h003, -1, 0, 10, 1'b0, 1'b0};
        vecs[3] = '{10'h155,  0, 1, 11, 1'b1, 1'b0};
        vecs[4] = '{10'h200,  9, 2, 12, 1'b1, 1'b0};
        vecs[5] = '{10'h2C5, -1, 0, 10, 1'b1, 1'b1};

        // Power-on reset, released mid-cycle.
        repeat (2) @(negedge clk);
        chk("rst_load_ready", bus.load_ready, 0);
        chk("rst_ser_valid", bus.ser_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        #2 reset = 1'b0;
        #1 chk("load_ready_before_edge", bus.load_ready, 0);
        @(posedge clk);
        #1 chk("load_ready_first_edge", bus.load_ready, 1);

        // Asynchronous assertion mid-clock, held for 3 cycles.
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async_rst_load_ready", bus.load_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1 chk("load_ready_after_rst", bus.load_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // load_valid held through the previous transfer: 0x3FF accepted WIDTH+2(+parity) edges later.
        prev_acc = acc_edge;
        run_vec('{10'h3FF, -1, 0, 10, 1'b0, 1'b0});
        chk("busy_load_accept_gap", acc_edge - prev_acc, W + 2 + PAR);

        // Abort during the sixth bit of 0x2C5.
        bus.load_valid = 1'b1;
        bus.load_data  = 10'h2C5;
        bus.ser_ready  = 1'b1;
        @(posedge clk);
        #1 bus.load_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("abort_sixth_bit_valid", bus.ser_valid, 1);
        chk("abort_sixth_bit_value", bus.ser_out, 0);
        #2 reset = 1'b1;
        #1;
        chk("abort_ser_valid", bus.ser_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done++;
        end
        chk("no_done_after_abort", seen_done, 0);
        chk("idle_after_abort", bus.load_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
